cache_write_merge_buffer: RTL and testbench

- Multi-entry write-combining buffer between the CPU store path and the cache line array.
- Accumulates partial-word stores into full-line images with a per-byte mask.
- Merges repeat stores to the same line.
- Drains completed, aged or flushed lines to the line array over a valid/ready handshake. The consumer applies the byte mask to the stored line.

---
 rtl/cache_write_merge_buffer.sv | 232 +++++++++++++++++++++++
 tb/tb_cache_write_merge_buffer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_write_merge_buffer.sv
// cache_write_merge_buffer
//   Write-combining buffer between the CPU store path and the cache line
//   array. Partial-word stores are merged into per-entry line images with a
//   per-byte mask; lines drain oldest-first over a valid/ready handshake when
//   the buffer is full, the head line is completely written, or flush is high.
//
//   Optional build macro: CWMB_FWD_EN enables combinational store-to-load
//   forwarding on the ld_* ports (youngest matching entry wins). Without it
//   ld_hit/ld_data/ld_mask are tied to zero and ld_addr is ignored.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   st_valid/st_ready   store handshake; st_addr, st_wdata, st_byte_enable
//                       are lane-0 aligned and shifted by st_addr[1:0]
//   flush               level; drains every entry while high
//   empty               no valid entries
//   wb_valid/wb_ready   drain handshake; wb_addr (line aligned), wb_data
//                       (line image), wb_mask (written bytes)
//   ld_addr             forwarding probe; ld_hit, ld_data, ld_mask results
module cache_write_merge_buffer #(
   parameter int ADDR_WIDTH  = 32,
   parameter int OFFSET_BITS = 5,
   parameter int DEPTH       = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          st_valid,
   output logic                          st_ready,
   input  logic [ADDR_WIDTH-1:0]         st_addr,
   input  logic [31:0]                   st_wdata,
   input  logic [3:0]                    st_byte_enable,
   input  logic                          flush,
   output logic                          empty,
   output logic                          wb_valid,
   input  logic                          wb_ready,
   output logic [ADDR_WIDTH-1:0]         wb_addr,
   output logic [(8<<OFFSET_BITS)-1:0]   wb_data,
   output logic [(1<<OFFSET_BITS)-1:0]   wb_mask,
   input  logic [ADDR_WIDTH-1:0]         ld_addr,
   output logic                          ld_hit,
   output logic [31:0]                   ld_data,
   output logic [3:0]                    ld_mask
);

   localparam int LB        = 1 << OFFSET_BITS;   // bytes per line
   localparam int LINE_BITS = 8 * LB;
   localparam int TAG_W     = ADDR_WIDTH - OFFSET_BITS;
   localparam int WSEL_W    = OFFSET_BITS - 2;
   localparam int RW        = $clog2(DEPTH) + 1;  // holds 0..DEPTH
   localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_DRAINING} ent_state_e;

   // rank = age order among non-empty entries, 0 = oldest. Only the oldest
   // entry ever drains, so a free simply decrements everyone else.
   typedef struct packed {
      ent_state_e            state;
      logic [RW-1:0]         rank;
      logic [TAG_W-1:0]      tag;
      logic [LB-1:0]         mask;
      logic [LINE_BITS-1:0]  data;
   } entry_t;

   entry_t ent_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wb_addr_q;
   logic [LINE_BITS-1:0]  wb_data_q;
   logic [LB-1:0]         wb_mask_q;
   logic                  wb_valid_q;

   logic [3:0]            lanes;
   logic [7:0]            be_ext;
   logic [31:0]           wdata_al;
   logic [TAG_W-1:0]      st_tag;
   logic [WSEL_W-1:0]     st_word;
   logic [LB-1:0]         wr_mask;
   logic [LINE_BITS-1:0]  wr_data;
   logic [LINE_BITS-1:0]  wr_bmask;

   logic                  hit, any_empty, drain_active, head_found;
   logic [IW-1:0]         hit_idx, alloc_idx, drain_idx, head_idx;
   logic [RW-1:0]         n_busy, alloc_rank;
   logic                  accept, wb_fire, full, start_drain;

   // ---------------- store alignment and entry lookup ----------------
   always_comb begin
      be_ext   = {4'b0000, st_byte_enable} << st_addr[1:0];
      lanes    = be_ext[3:0];              // lanes past 3 are dropped
      wdata_al = st_wdata << {st_addr[1:0], 3'b000};
      st_tag   = st_addr[ADDR_WIDTH-1:OFFSET_BITS];
      st_word  = st_addr[OFFSET_BITS-1:2];

      wr_mask  = '0;
      wr_data  = '0;
      wr_bmask = '0;
      for (int b = 0; b < LB; b++) begin
         if ((b >> 2) == int'(st_word) && lanes[b[1:0]]) begin
            wr_mask[b]          = 1'b1;
            wr_data[8*b +: 8]   = wdata_al[8*b[1:0] +: 8];
            wr_bmask[8*b +: 8]  = 8'hFF;
         end
      end

      hit          = 1'b0;
      hit_idx      = '0;
      any_empty    = 1'b0;
      alloc_idx    = '0;
      drain_active = 1'b0;
      drain_idx    = '0;
      head_found   = 1'b0;
      head_idx     = '0;
      n_busy       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].state == S_FILLING && ent_q[i].tag == st_tag) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
         if (ent_q[i].state == S_EMPTY && !any_empty) begin
            any_empty = 1'b1;
            alloc_idx = IW'(i);
         end
         if (ent_q[i].state == S_DRAINING) begin
            drain_active = 1'b1;
            drain_idx    = IW'(i);
         end
         // a rank-0 FILLING entry only exists when nothing is draining
         if (ent_q[i].state == S_FILLING && ent_q[i].rank == '0) begin
            head_found = 1'b1;
            head_idx   = IW'(i);
         end
         if (ent_q[i].state != S_EMPTY) n_busy = n_busy + 1'b1;
      end
   end

   assign st_ready    = hit || any_empty;
   assign accept      = st_valid && st_ready;
   assign wb_fire     = wb_valid_q && wb_ready;
   assign full        = (n_busy == RW'(DEPTH));
   assign start_drain = !drain_active && head_found &&
                        (full || (&ent_q[head_idx].mask) || flush);
   assign alloc_rank  = n_busy - RW'(wb_fire);
   assign empty       = (n_busy == '0);

   // ---------------- entry state and drain register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         wb_mask_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wb_fire && drain_idx == IW'(i)) begin
               ent_q[i].state <= S_EMPTY;
               ent_q[i].mask  <= '0;
            end else if (start_drain && head_idx == IW'(i)) begin
               ent_q[i].state <= S_DRAINING;
            end
            if (wb_fire && drain_idx != IW'(i) && ent_q[i].state != S_EMPTY)
               ent_q[i].rank <= ent_q[i].rank - 1'b1;
            // merge into the head on the edge it locks is intentional: the
            // line image is snapshotted into wb_* one edge later.
            if (accept && !hit && alloc_idx == IW'(i)) begin
               ent_q[i].state <= S_FILLING;
               ent_q[i].rank  <= alloc_rank;
               ent_q[i].tag   <= st_tag;
               ent_q[i].mask  <= wr_mask;
               ent_q[i].data  <= wr_data;
            end else if (accept && hit && hit_idx == IW'(i)) begin
               ent_q[i].mask  <= ent_q[i].mask | wr_mask;
               ent_q[i].data  <= (ent_q[i].data & ~wr_bmask) | wr_data;
            end
         end

         if (wb_fire) begin
            wb_valid_q <= 1'b0;
         end else if (drain_active && !wb_valid_q) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= {ent_q[drain_idx].tag, {OFFSET_BITS{1'b0}}};
            wb_data_q  <= ent_q[drain_idx].data;
            wb_mask_q  <= ent_q[drain_idx].mask;
         end
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_addr  = wb_addr_q;
   assign wb_data  = wb_data_q;
   assign wb_mask  = wb_mask_q;

   // ---------------- store-to-load forwarding ----------------
`ifdef CWMB_FWD_EN
   logic               fwd_found;
   logic [IW-1:0]      fwd_idx;
   logic [RW-1:0]      fwd_rank;
   logic [WSEL_W-1:0]  ld_word;
   logic               ld_addr_unused;

   assign ld_word        = ld_addr[OFFSET_BITS-1:2];
   assign ld_addr_unused = ^ld_addr[1:0];

   always_comb begin
      fwd_found = 1'b0;
      fwd_idx   = '0;
      fwd_rank  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].state != S_EMPTY &&
             ent_q[i].tag == ld_addr[ADDR_WIDTH-1:OFFSET_BITS] &&
             (!fwd_found || ent_q[i].rank > fwd_rank)) begin
            fwd_found = 1'b1;
            fwd_idx   = IW'(i);
            fwd_rank  = ent_q[i].rank;
         end
      end
      ld_mask = 4'b0000;
      ld_data = '0;
      if (fwd_found) begin
         ld_mask = ent_q[fwd_idx].mask[4*ld_word +: 4];
         ld_data = ent_q[fwd_idx].data[32*ld_word +: 32];
      end
      ld_hit = fwd_found && (ld_mask != 4'b0000);
   end
`else
   logic ld_addr_unused;
   assign ld_addr_unused = ^ld_addr;
   assign ld_hit  = 1'b0;
   assign ld_data = '0;
   assign ld_mask = '0;
`endif

endmodule

// File: tb/tb_cache_write_merge_buffer.sv
module tb_cache_write_merge_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic         st_valid;
   logic         st_ready;
   logic [31:0]  st_addr;
   logic [31:0]  st_wdata;
   logic [3:0]   st_byte_enable;
   logic         flush;
   logic         empty;
   logic         wb_valid;
   logic         wb_ready;
   logic [31:0]  wb_addr;
   logic [255:0] wb_data;
   logic [31:0]  wb_mask;
   logic [31:0]  ld_addr;
   logic         ld_hit;
   logic [31:0]  ld_data;
   logic [3:0]   ld_mask;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cache_write_merge_buffer dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_wdata(st_wdata), .st_byte_enable(st_byte_enable),
      .flush(flush), .empty(empty),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
      .wb_data(wb_data), .wb_mask(wb_mask),
      .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_mask(ld_mask)
   );

   // issue one store, waiting (bounded) for st_ready; returns at the negedge
   // after acceptance
   task automatic store(input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      st_valid = 1'b1; st_addr = a; st_byte_enable = be; st_wdata = d;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         if (st_ready) begin
            ok = 1'b1;
            @(posedge clk);
         end
         @(negedge clk);
      end
      st_valid = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL store_accept addr=%h got=timeout exp=accepted", a);
      end
   endtask

   // wait (bounded) for wb_valid, sampled on negedges
   task automatic wait_drain(input string name, output logic got);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (wb_valid) got = 1'b1;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL %s_wb_valid got=timeout exp=drain", name);
      end
   endtask

   task automatic accept_drain();
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks += 7;
      if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
      if (wb_addr !== 32'h0) begin failures++; $display("FAIL rst_wb_addr got=%h exp=0", wb_addr); end
      if (wb_data !== 256'h0) begin failures++; $display("FAIL rst_wb_data got=%h exp=0", wb_data); end
      if (wb_mask !== 32'h0) begin failures++; $display("FAIL rst_wb_mask got=%h exp=0", wb_mask); end
      if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
      if (st_ready !== 1'b1) begin failures++; $display("FAIL rst_st_ready got=%b exp=1", st_ready); end
      if (ld_hit !== 1'b0) begin failures++; $display("FAIL rst_ld_hit got=%b exp=0", ld_hit); end
      rst = 1'b0;
   endtask

   task automatic test_flush_single();
      logic got;
      store(32'h100, 4'b1111, 32'hDEADBEEF);
      checks++;
      if (empty !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", empty); end
      flush = 1'b1;
      wait_drain("single", got);
      if (got) begin
         checks += 3;
         if (wb_addr !== 32'h100) begin failures++; $display("FAIL single_addr got=%h exp=00000100", wb_addr); end
         if (wb_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", wb_data[31:0]); end
         if (wb_mask !== 32'h0000000F) begin failures++; $display("FAIL single_mask got=%h exp=0000000f", wb_mask); end
         accept_drain();
      end
      flush = 1'b0;
      checks++;
      if (empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b exp=1", empty); end
   endtask

   task automatic test_misaligned();
      logic got;
      store(32'h203, 4'b0001, 32'h000000AB);
      flush = 1'b1;
      wait_drain("misal", got);
      if (got) begin
         checks += 3;
         if (wb_addr !== 32'h200) begin failures++; $display("FAIL misal_addr got=%h exp=00000200", wb_addr); end
         if (wb_data[31:24] !== 8'hAB) begin failures++; $display("FAIL misal_data got=%h exp=ab", wb_data[31:24]); end
         if (wb_mask !== 32'h00000008) begin failures++; $display("FAIL misal_mask got=%h exp=00000008", wb_mask); end
         accept_drain();
      end
      flush = 1'b0;
   endtask

   task automatic test_truncation();
      logic got;
      store(32'h302, 4'b1111, 32'h11223344);
      flush = 1'b1;
      wait_drain("trunc", got);
      if (got) begin
         checks += 3;
         if (wb_addr !== 32'h300) begin failures++; $display("FAIL trunc_addr got=%h exp=00000300", wb_addr); end
         if (wb_data[31:16] !== 16'h3344) begin failures++; $display("FAIL trunc_data got=%h exp=3344", wb_data[31:16]); end
         if (wb_mask !== 32'h0000000C) begin failures++; $display("FAIL trunc_mask got=%h exp=0000000c", wb_mask); end
         accept_drain();
      end
      flush = 1'b0;
   endtask

   task automatic test_full_line();
      logic got;
      for (int k = 0; k < 8; k++)
         store(32'h400 + 32'(4*k), 4'b1111, 32'hC0DE0000 | 32'(k));
      wait_drain("full", got);
      if (got) begin
         for (int s = 0; s < 4; s++) begin
            checks += 5;
            if (wb_valid !== 1'b1) begin failures++; $display("FAIL full_valid_c%0d got=%b exp=1", s, wb_valid); end
            if (wb_addr !== 32'h400) begin failures++; $display("FAIL full_addr_c%0d got=%h exp=00000400", s, wb_addr); end
            if (wb_mask !== 32'hFFFFFFFF) begin failures++; $display("FAIL full_mask_c%0d got=%h exp=ffffffff", s, wb_mask); end
            if (wb_data[31:0] !== 32'hC0DE0000) begin failures++; $display("FAIL full_w0_c%0d got=%h exp=c0de0000", s, wb_data[31:0]); end
            if (wb_data[255:224] !== 32'hC0DE0007) begin failures++; $display("FAIL full_w7_c%0d got=%h exp=c0de0007", s, wb_data[255:224]); end
            if (s < 3) @(negedge clk);
         end
         accept_drain();
      end
      checks++;
      if (empty !== 1'b1) begin failures++; $display("FAIL full_empty got=%b exp=1", empty); end
   endtask

   task automatic test_capacity();
      logic got;
      store(32'h500, 4'b1111, 32'h00000055);
      store(32'h600, 4'b1111, 32'h00000066);
      wait_drain("cap0", got);
      if (got) begin
         checks++;
         if (wb_addr !== 32'h500) begin failures++; $display("FAIL cap0_addr got=%h exp=00000500", wb_addr); end
      end
      st_valid = 1'b1; st_addr = 32'h700; st_byte_enable = 4'b1111; st_wdata = 32'h00000077;
      for (int s = 0; s < 3; s++) begin
         #1;
         checks++;
         if (st_ready !== 1'b0) begin failures++; $display("FAIL cap_stall_c%0d got=%b exp=0", s, st_ready); end
         if (s < 2) @(negedge clk);
      end
      wb_ready = 1'b1;
      #1;
      checks++;
      if (st_ready !== 1'b0) begin failures++; $display("FAIL cap_handshake_cycle got=%b exp=0", st_ready); end
      @(negedge clk);
      wb_ready = 1'b0;
      #1;
      checks++;
      if (st_ready !== 1'b1) begin failures++; $display("FAIL cap_after_free got=%b exp=1", st_ready); end
      @(posedge clk);
      @(negedge clk);
      st_valid = 1'b0;
      wait_drain("cap1", got);
      if (got) begin
         checks += 2;
         if (wb_addr !== 32'h600) begin failures++; $display("FAIL cap1_addr got=%h exp=00000600", wb_addr); end
         if (wb_data[31:0] !== 32'h66) begin failures++; $display("FAIL cap1_data got=%h exp=00000066", wb_data[31:0]); end
         accept_drain();
      end
      flush = 1'b1;
      wait_drain("cap2", got);
      if (got) begin
         checks += 2;
         if (wb_addr !== 32'h700) begin failures++; $display("FAIL cap2_addr got=%h exp=00000700", wb_addr); end
         if (wb_data[31:0] !== 32'h77) begin failures++; $display("FAIL cap2_data got=%h exp=00000077", wb_data[31:0]); end
         accept_drain();
      end
      flush = 1'b0;
      checks++;
      if (empty !== 1'b1) begin failures++; $display("FAIL cap_empty got=%b exp=1", empty); end
   endtask

   // a store to the line being drained must open a fresh entry
   task automatic test_drain_realloc();
      logic got;
      store(32'h500, 4'b0001, 32'h00000011);
      flush = 1'b1;
      wait_drain("realloc0", got);
      flush = 1'b0;
      if (got) begin
         checks += 2;
         if (wb_mask !== 32'h1) begin failures++; $display("FAIL realloc0_mask got=%h exp=00000001", wb_mask); end
         if (wb_data[7:0] !== 8'h11) begin failures++; $display("FAIL realloc0_data got=%h exp=11", wb_data[7:0]); end
      end
      #1;
      checks++;
      if (st_ready !== 1'b1) begin failures++; $display("FAIL realloc_ready got=%b exp=1", st_ready); end
      store(32'h500, 4'b0010, 32'h00002200);
      if (got) accept_drain();
      flush = 1'b1;
      wait_drain("realloc1", got);
      if (got) begin
         checks += 3;
         if (wb_addr !== 32'h500) begin failures++; $display("FAIL realloc1_addr got=%h exp=00000500", wb_addr); end
         if (wb_mask !== 32'h2) begin failures++; $display("FAIL realloc1_mask got=%h exp=00000002", wb_mask); end
         if (wb_data[15:8] !== 8'h22) begin failures++; $display("FAIL realloc1_data got=%h exp=22", wb_data[15:8]); end
         accept_drain();
      end
      flush = 1'b0;
   endtask

   task automatic test_reset_drop();
      logic got;
      logic seen;
      store(32'hA00, 4'b1111, 32'h0000AAAA);
      flush = 1'b1;
      wait_drain("rstdrop", got);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks += 2;
      if (wb_valid !== 1'b0) begin failures++; $display("FAIL rstdrop_valid got=%b exp=0", wb_valid); end
      if (empty !== 1'b1) begin failures++; $display("FAIL rstdrop_empty got=%b exp=1", empty); end
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (wb_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin failures++; $display("FAIL rstdrop_reissue got=%b exp=0", seen); end
      flush = 1'b0;
   endtask

   task automatic test_forward();
      logic got;
      store(32'h800, 4'b0011, 32'h00005566);
      ld_addr = 32'h800;
      #1;
`ifdef CWMB_FWD_EN
      checks += 3;
      if (ld_hit !== 1'b1) begin failures++; $display("FAIL fwd_hit got=%b exp=1", ld_hit); end
      if (ld_mask !== 4'b0011) begin failures++; $display("FAIL fwd_mask got=%b exp=0011", ld_mask); end
      if (ld_data[15:0] !== 16'h5566) begin failures++; $display("FAIL fwd_data got=%h exp=5566", ld_data[15:0]); end
      ld_addr = 32'h804;
      #1;
      checks++;
      if (ld_hit !== 1'b0) begin failures++; $display("FAIL fwd_nomask_hit got=%b exp=0", ld_hit); end
`else
      checks += 2;
      if (ld_hit !== 1'b0) begin failures++; $display("FAIL fwd_off_hit got=%b exp=0", ld_hit); end
      if (ld_mask !== 4'b0000) begin failures++; $display("FAIL fwd_off_mask got=%b exp=0000", ld_mask); end
`endif
      flush = 1'b1;
      wait_drain("fwd", got);
      if (got) begin
         checks++;
         if (wb_mask !== 32'h3) begin failures++; $display("FAIL fwd_wb_mask got=%h exp=00000003", wb_mask); end
         accept_drain();
      end
      flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_wdata = '0;
      st_byte_enable = '0; flush = 1'b0; wb_ready = 1'b0; ld_addr = '0;
      test_reset();
      test_flush_single();
      test_misaligned();
      test_truncation();
      test_full_line();
      test_capacity();
      test_drain_realloc();
      test_reset_drop();
      test_forward();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
